imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Owns the byte-organised instruction memory port. Shares it between two requesters: the IF-stage fetch (read-only) and the program loader/debug port (write-only).
- Serialises their requests into single-word MemRead/MemWrite accesses and checks word alignment and range.
- Returns read data or write acknowledge with fixed latency. Sits between the IF stage / loader and the instruction memory.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses.
- DATA_WIDTH, 32, instruction word width (4 bytes, big-endian packing in memory).
- MEM_BYTES, 1024, instruction memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
- LOADER_BURST_MAX, 4, max consecutive loader grants while a fetch is waiting.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous active-high reset.
- fetch_req  in  1  fetch read request; held with fetch_addr until fetch_gnt.
- fetch_addr  in  ADDR_WIDTH  fetch byte address.
- fetch_gnt  out  1  one-cycle pulse: request consumed.
- fetch_rvalid  out  1  one-cycle pulse: fetch_rdata/fetch_err valid.
- fetch_rdata  out  DATA_WIDTH  read word; 0 on error.
- fetch_err  out  1  misaligned or out-of-range; qualified by fetch_rvalid.
- ld_req  in  1  loader write request; held with ld_addr/ld_wdata until ld_gnt.
- ld_addr  in  ADDR_WIDTH  loader byte address.
- ld_wdata  in  DATA_WIDTH  loader write word.
- ld_gnt  out  1  one-cycle pulse: request consumed.
- ld_ack  out  1  one-cycle pulse: write complete (or rejected).
- ld_err  out  1  misaligned or out-of-range; qualified by ld_ack.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_write_data  out  DATA_WIDTH  to memory WriteData.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_read_data  in  DATA_WIDTH  from memory ReadData (registered in memory).

Behaviour:
- Reset: asynchronous, takes effect immediately. FSM to IDLE; burst counter 0; every output 0. Any in-flight access is dropped; no gnt, rvalid or ack is produced for it.
- All outputs are registered.
- FSM states: IDLE, ISSUE_RD, RESP_RD, ISSUE_WR.
- IDLE arbitration, evaluated each edge:
  - Loader wins if ld_req, unless fetch_req is high and the burst counter equals LOADER_BURST_MAX; then fetch wins.
  - Burst counter: +1 on a loader grant while fetch_req=1; cleared on any fetch grant, and on a loader grant with fetch_req=0.
- Read path:
  - Edge E0 (IDLE, fetch wins): latch address; fetch_gnt=1 for cycle 1; state -> ISSUE_RD. If legal: mem_read=1, mem_address=addr.
  - Edge E1: mem_read=0; state -> RESP_RD.
  - Edge E2: fetch_rvalid=1, fetch_rdata=mem_read_data (0 if error), fetch_err as checked; state -> IDLE.
  - Latency: grant edge to rvalid cycle is 3 cycles. A new arbitration happens at edge E3.
- Write path:
  - Edge E0 (IDLE, loader wins): ld_gnt=1; state -> ISSUE_WR. If legal: mem_write=1, mem_address/mem_write_data driven.
  - Edge E1: mem_write=0; ld_ack=1, ld_err as checked; state -> IDLE.
  - Back-to-back writes every 2 cycles.
- Legality: addr[1:0]==0 and addr <= MEM_BYTES-4. Illegal requests keep identical timing with mem_read/mem_write held 0.
- mem_read and mem_write are never both 1.
- A req still high in the cycle after its gnt is not re-granted until the FSM returns to IDLE. A req still high at that point is treated as a new request.
- Requests arriving in non-IDLE states wait; they are never dropped.

Optional Feature:
- Macro IMEM_ARB_STATS_EN.
- Defined: adds output fetch_stall_cnt [15:0]. It increments each cycle fetch_req=1 and no fetch grant occurs at that edge, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- After reset, fetch_req with fetch_addr=4 -> fetch_gnt 1 cycle later; fetch_rvalid 3 cycles after grant edge with fetch_rdata=32'hE3A00014, fetch_err=0.
- ld_req addr=24, wdata=32'hE1A00000, then fetch addr=24 -> ld_ack with ld_err=0; fetch_rdata=32'hE1A00000.
- fetch_addr=6 and separately ld_addr=MEM_BYTES -> fetch_err=1 with rdata=0; ld_err=1; mem_read/mem_write never asserted.
- ld_req held continuously while fetch_req=1, LOADER_BURST_MAX=4 -> exactly 4 ld_gnt, then fetch_gnt, then loader resumes.
- Simultaneous ld_req and fetch_req from idle with counter 0 -> loader granted first.
- rst pulsed during ISSUE_RD -> all outputs 0 immediately, no fetch_rvalid; the next request is served normally. With IMEM_ARB_STATS_EN, fetch_stall_cnt counts blocked cycles, e.g. 8 during the burst test.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares the byte-addressed instruction memory port between the IF-stage
// fetch (read-only) and the program loader (write-only). Each request becomes
// one word access with a fixed response latency. Alignment and range are
// checked, and illegal requests keep the same timing without strobing memory.
// Optional build macro: IMEM_ARB_STATS_EN adds the fetch_stall_cnt output.
module imem_arbiter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_BYTES        = 1024,
    parameter int LOADER_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    output logic                  fetch_err,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_ack,
    output logic                  ld_err,
`ifdef IMEM_ARB_STATS_EN
    output logic [15:0]           fetch_stall_cnt,
`endif
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int CNT_W = (LOADER_BURST_MAX < 1) ? 1 : $clog2(LOADER_BURST_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_WORD_ADDR = ADDR_WIDTH'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0]      BURST_LIMIT   = CNT_W'(LOADER_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_RD = 2'd1,
        RESP_RD  = 2'd2,
        ISSUE_WR = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_burst;
    logic                  r_err;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_burst_nxt;
    logic                  w_err_nxt;
    logic                  w_fetch_gnt_nxt;
    logic                  w_fetch_rvalid_nxt;
    logic [DATA_WIDTH-1:0] w_fetch_rdata_nxt;
    logic                  w_fetch_err_nxt;
    logic                  w_ld_gnt_nxt;
    logic                  w_ld_ack_nxt;
    logic                  w_ld_err_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_address_nxt;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
    logic                  w_mem_read_nxt;
    logic                  w_mem_write_nxt;

    logic                  w_fetch_legal;
    logic                  w_ld_legal;
    logic                  w_ld_win;
    logic                  w_fetch_win;

    // A word access is legal when aligned and fully inside the memory.
    function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a <= MAX_WORD_ADDR);
    endfunction

    // Arbitration decision; only meaningful while IDLE.
    always_comb begin
        w_fetch_legal = addr_legal(fetch_addr);
        w_ld_legal    = addr_legal(ld_addr);
        w_ld_win      = (r_state == IDLE) && ld_req &&
                        !(fetch_req && (r_burst == BURST_LIMIT));
        w_fetch_win   = (r_state == IDLE) && fetch_req && !w_ld_win;
    end

    // Next-state and next-output computation; every output is a one-cycle
    // pulse unless set again, address/write-data hold between accesses.
    always_comb begin
        w_state_nxt        = r_state;
        w_burst_nxt        = r_burst;
        w_err_nxt          = r_err;
        w_fetch_gnt_nxt    = 1'b0;
        w_fetch_rvalid_nxt = 1'b0;
        w_fetch_rdata_nxt  = '0;
        w_fetch_err_nxt    = 1'b0;
        w_ld_gnt_nxt       = 1'b0;
        w_ld_ack_nxt       = 1'b0;
        w_ld_err_nxt       = 1'b0;
        w_mem_address_nxt  = mem_address;
        w_mem_wdata_nxt    = mem_write_data;
        w_mem_read_nxt     = 1'b0;
        w_mem_write_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ld_win) begin
                    w_ld_gnt_nxt = 1'b1;
                    w_err_nxt    = !w_ld_legal;
                    w_burst_nxt  = fetch_req ? (r_burst + CNT_W'(1)) : '0;
                    if (w_ld_legal) begin
                        w_mem_write_nxt   = 1'b1;
                        w_mem_address_nxt = ld_addr;
                        w_mem_wdata_nxt   = ld_wdata;
                    end
                    w_state_nxt = ISSUE_WR;
                end else if (w_fetch_win) begin
                    w_fetch_gnt_nxt = 1'b1;
                    w_err_nxt       = !w_fetch_legal;
                    w_burst_nxt     = '0;
                    if (w_fetch_legal) begin
                        w_mem_read_nxt    = 1'b1;
                        w_mem_address_nxt = fetch_addr;
                    end
                    w_state_nxt = ISSUE_RD;
                end
            end
            ISSUE_RD: begin
                // Memory registers the read on this edge.
                w_state_nxt = RESP_RD;
            end
            RESP_RD: begin
                w_fetch_rvalid_nxt = 1'b1;
                w_fetch_err_nxt    = r_err;
                w_fetch_rdata_nxt  = r_err ? '0 : mem_read_data;
                w_state_nxt        = IDLE;
            end
            ISSUE_WR: begin
                w_ld_ack_nxt = 1'b1;
                w_ld_err_nxt = r_err;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_burst        <= '0;
            r_err          <= 1'b0;
            fetch_gnt      <= 1'b0;
            fetch_rvalid   <= 1'b0;
            fetch_rdata    <= '0;
            fetch_err      <= 1'b0;
            ld_gnt         <= 1'b0;
            ld_ack         <= 1'b0;
            ld_err         <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_burst        <= w_burst_nxt;
            r_err          <= w_err_nxt;
            fetch_gnt      <= w_fetch_gnt_nxt;
            fetch_rvalid   <= w_fetch_rvalid_nxt;
            fetch_rdata    <= w_fetch_rdata_nxt;
            fetch_err      <= w_fetch_err_nxt;
            ld_gnt         <= w_ld_gnt_nxt;
            ld_ack         <= w_ld_ack_nxt;
            ld_err         <= w_ld_err_nxt;
            mem_address    <= w_mem_address_nxt;
            mem_write_data <= w_mem_wdata_nxt;
            mem_read       <= w_mem_read_nxt;
            mem_write      <= w_mem_write_nxt;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    // Count edges where a fetch is requested but not granted; saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_stall_cnt <= '0;
        end else if (fetch_req && !w_fetch_win && (fetch_stall_cnt != 16'hFFFF)) begin
            fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed vector table, hand-written reset and
// burst sequences, then randomized traffic against a transaction-level model.
module tb_imem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MEM_BYTES = 1024;
    localparam int BURST     = 4;
    localparam int WORDS     = MEM_BYTES / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          fetch_err;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_ack;
    logic          ld_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_read_data;
`ifdef IMEM_ARB_STATS_EN
    logic [15:0]   fetch_stall_cnt;
`endif

    imem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MEM_BYTES(MEM_BYTES), .LOADER_BURST_MAX(BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
        .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_ack(ld_ack), .ld_err(ld_err),
`ifdef IMEM_ARB_STATS_EN
        .fetch_stall_cnt(fetch_stall_cnt),
`endif
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory model: registered read, one word per access.
    logic [31:0] tb_mem [0:WORDS-1];
    logic        mem_init;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hE3A00014 : (32'h10000000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) tb_mem[i] <= init_word(i);
        end else begin
            if (mem_read)
                mem_read_data <= (mem_address < 32'(MEM_BYTES)) ? tb_mem[int'(mem_address >> 2)] : 32'hDEADBEEF;
            if (mem_write && (mem_address < 32'(MEM_BYTES)))
                tb_mem[int'(mem_address >> 2)] <= mem_write_data;
        end
    end

    // Reference contents of memory as the requesters should see it.
    logic [31:0] ref_w [0:WORDS-1];

    function automatic logic is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
    endfunction

    function automatic logic [127:0] outs();
        return {fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, ld_gnt, ld_ack, ld_err,
                mem_address, mem_write_data, mem_read, mem_write};
    endfunction

    function automatic logic [31:0] rnd_addr();
        int sel = $urandom_range(0, 9);
        case (sel)
            0: return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            1: return 32'(MEM_BYTES) + 32'($urandom_range(0, 3) * 4);
            2: return 32'hFFFFFFFC;
            3: return 32'(MEM_BYTES - 4);
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    typedef struct {
        logic        is_ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    // Apply one request from idle and check grant, strobes and response timing.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (v.is_ld) begin
            ld_req = 1'b1; ld_addr = v.addr; ld_wdata = v.wdata;
        end else begin
            fetch_req = 1'b1; fetch_addr = v.addr;
        end
        @(posedge clk); #1;
        chk({tag, "_gnt"}, {fetch_gnt, ld_gnt}, v.is_ld ? 2'b01 : 2'b10);
        chk({tag, "_strobe"}, {mem_read, mem_write}, v.exp_err ? 2'b00 : (v.is_ld ? 2'b01 : 2'b10));
        ld_req = 1'b0; fetch_req = 1'b0;
        if (v.is_ld) begin
            @(posedge clk); #1;
            chk({tag, "_ack"}, {ld_ack, ld_err, mem_read, mem_write}, {1'b1, v.exp_err, 2'b00});
            if (!v.exp_err) ref_w[int'(v.addr >> 2)] = v.wdata;
        end else begin
            @(posedge clk); #1;
            chk({tag, "_mid"}, {fetch_rvalid, mem_read, mem_write}, 3'b000);
            @(posedge clk); #1;
            chk({tag, "_rsp"}, {fetch_rvalid, fetch_err, fetch_rdata}, {1'b1, v.exp_err, v.exp_rdata});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  seq;
        int          ngr;
        int          k, free_at, streak, f_due, l_due;
        logic        f_err, l_err, lg;
        logic [31:0] f_data;
        logic        exp_fg, exp_lg, exp_mr, exp_mw;
        logic [31:0] exp_addr, exp_wd;

        vecs[0]  = '{1'b0, 32'd4,                  32'h0,        1'b0, 32'hE3A00014};
        vecs[1]  = '{1'b1, 32'd24,                 32'hE1A00000, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'd24,                 32'h0,        1'b0, 32'hE1A00000};
        vecs[3]  = '{1'b0, 32'd6,                  32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'(MEM_BYTES),         32'h12345678, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'(MEM_BYTES - 4),     32'h0,        1'b0, 32'h100000FF};
        vecs[6]  = '{1'b1, 32'd2,                  32'h87654321, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFC,           32'h0,        1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'(MEM_BYTES - 4),     32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'(MEM_BYTES - 4),     32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[10] = '{1'b0, 32'(MEM_BYTES),         32'h0,        1'b1, 32'h0};

        for (int i = 0; i < WORDS; i++) ref_w[i] = init_word(i);

        rst = 1'b1; mem_init = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;

        // Reset state
        @(posedge clk); #1;
        chk("reset_outs", outs(), 128'd0);
`ifdef IMEM_ARB_STATS_EN
        chk("reset_stall", fetch_stall_cnt, 16'd0);
`endif
        @(negedge clk); mem_init = 1'b0; rst = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Asynchronous reset while a read is in ISSUE_RD
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'd4;
        @(posedge clk); #1;
        chk("rst_pre_gnt", {fetch_gnt, mem_read}, 2'b11);
        fetch_req = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async_outs", outs(), 128'd0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("rst_no_rvalid", fetch_rvalid, 1'b0);
        end
        run_vec(vecs[2], 20);

        // Loader burst against a waiting fetch; first grant also covers the
        // simultaneous-request case with the counter at zero.
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 32'd40; ld_wdata = 32'hCAFE0000;
        fetch_req = 1'b1; fetch_addr = 32'd40;
        seq = '0; ngr = 0;
        for (int c = 0; c < 40 && ngr < 6; c++) begin
            @(posedge clk); #1;
            if (fetch_rvalid) chk("burst_rdata", {fetch_err, fetch_rdata}, {1'b0, 32'hCAFE0000});
            if (ld_gnt || fetch_gnt) begin
                seq = {seq[4:0], fetch_gnt};
                ngr++;
            end
            if (fetch_gnt) begin
                fetch_req = 1'b0;
`ifdef IMEM_ARB_STATS_EN
                chk("burst_stall_cnt", fetch_stall_cnt, 16'd8);
`endif
            end
        end
        ld_req = 1'b0;
        chk("burst_ngrants", ngr, 6);
        chk("burst_order", seq, 6'b000010);
        ref_w[10] = 32'hCAFE0000;
        repeat (4) @(posedge clk);

        // Randomized traffic against the transaction-level model
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        k = 0; free_at = 0; streak = 0; f_due = -1; l_due = -1;
        f_err = 1'b0; l_err = 1'b0; f_data = '0;
        for (int c = 0; c < 3000 && n_errors < 40; c++) begin
            @(posedge clk); k++;
            @(negedge clk);
            exp_fg = 1'b0; exp_lg = 1'b0; exp_mr = 1'b0; exp_mw = 1'b0;
            exp_addr = '0; exp_wd = '0;
            if (k >= free_at) begin
                if (ld_req && !(fetch_req && streak == BURST)) begin
                    lg = is_legal(ld_addr);
                    exp_lg = 1'b1; exp_mw = lg; exp_addr = ld_addr; exp_wd = ld_wdata;
                    streak = fetch_req ? streak + 1 : 0;
                    free_at = k + 2; l_due = k + 1; l_err = !lg;
                    if (lg) ref_w[int'(ld_addr >> 2)] = ld_wdata;
                end else if (fetch_req) begin
                    lg = is_legal(fetch_addr);
                    exp_fg = 1'b1; exp_mr = lg; exp_addr = fetch_addr;
                    streak = 0;
                    free_at = k + 3; f_due = k + 2; f_err = !lg;
                    f_data = lg ? ref_w[int'(fetch_addr >> 2)] : 32'h0;
                end
            end
            chk($sformatf("rnd_gnt@%0d", k), {fetch_gnt, ld_gnt}, {exp_fg, exp_lg});
            chk($sformatf("rnd_strobe@%0d", k), {mem_read, mem_write}, {exp_mr, exp_mw});
            if (exp_mr || exp_mw) chk($sformatf("rnd_addr@%0d", k), mem_address, exp_addr);
            if (exp_mw) chk($sformatf("rnd_wdata@%0d", k), mem_write_data, exp_wd);
            chk($sformatf("rnd_fresp@%0d", k),
                {fetch_rvalid, fetch_rvalid ? {fetch_err, fetch_rdata} : 33'd0},
                {(k == f_due), (k == f_due) ? {f_err, f_data} : 33'd0});
            chk($sformatf("rnd_lresp@%0d", k),
                {ld_ack, ld_ack & ld_err}, {(k == l_due), (k == l_due) & l_err});

            if (fetch_gnt) begin
                fetch_req = ($urandom_range(0, 3) != 0);
                if (fetch_req) fetch_addr = rnd_addr();
            end else if (!fetch_req && $urandom_range(0, 2) == 0) begin
                fetch_req = 1'b1; fetch_addr = rnd_addr();
            end
            if (ld_gnt) begin
                ld_req = ($urandom_range(0, 2) != 0);
                if (ld_req) begin ld_addr = rnd_addr(); ld_wdata = $urandom; end
            end else if (!ld_req && $urandom_range(0, 3) == 0) begin
                ld_req = 1'b1; ld_addr = rnd_addr(); ld_wdata = $urandom;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
